// File: rtl/ebus_pkg.sv
// Shared types and bit positions for the EBUS device responder.
// EBUS words are numbered 0..35 from the MSB; the constants below are
// the equivalent LSB-based indices (35 - bit).
package ebus_pkg;

  typedef enum logic [2:0] {
    F_CONO      = 3'd0,
    F_CONI      = 3'd1,
    F_DATAO     = 3'd2,
    F_DATAI     = 3'd3,
    F_PI_SERV   = 3'd4,
    F_PI_ADR_IN = 3'd5,
    F_RSV6      = 3'd6,
    F_RSV7      = 3'd7
  } tEBUSfunc;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } tDevState;

  // status (CONI) word: bit 27 IEN, 28 BUSY, 29 DONE, 33:35 PIA
  localparam int ST_IEN    = 35 - 27;
  localparam int ST_BUSY   = 35 - 28;
  localparam int ST_DONE   = 35 - 29;
  localparam int ST_PIA_LO = 35 - 35;

  // CONO word: bit 24 clr DONE, 25 set BUSY, 26 clr BUSY, 27 IEN, 33:35 PIA
  localparam int CO_CLR_DONE = 35 - 24;
  localparam int CO_SET_BUSY = 35 - 25;
  localparam int CO_CLR_BUSY = 35 - 26;
  localparam int CO_IEN      = 35 - 27;
  localparam int CO_PIA_LO   = 35 - 35;

  // functions whose ACK is followed by the device driving data
  function automatic logic is_read(input tEBUSfunc f);
    return (f == F_CONI) || (f == F_DATAI) || (f == F_PI_ADR_IN);
  endfunction

endpackage

// File: rtl/ebus_pi_req.sv
// Registered one-hot PI request: level PIA is requested while DONE & IEN.
module ebus_pi_req (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       done_i,
  input  logic       ien_i,
  input  logic [2:0] pia_i,
  output logic [6:0] pi_req_o
);
  logic [6:0] req_d, req_q;

  // decode PIA to its request line; PIA 0 means the device is not assigned
  always_comb begin
    req_d = '0;
    if (done_i && ien_i && (pia_i != 3'd0))
      req_d[pia_i - 3'd1] = 1'b1;
  end

  // one cycle of latency from the flag change
  always_ff @(posedge clk_i) begin
    if (rst_i) req_q <= '0;
    else       req_q <= req_d;
  end

  assign pi_req_o = req_q;
endmodule

// File: rtl/ebus_dev.sv
// Generic EBUS device responder: CS/function decode, DEMAND/ACK/XFER
// handshake, CONI/CONO status, DATAO/DATAI buffer and PI request/vector.
module ebus_dev
  import ebus_pkg::*;
#(
  parameter logic [6:0]  DEV_CS  = 7'o10,
  parameter int          ACK_DLY = 2,
  parameter logic [35:0] VECTOR  = 36'o0
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [6:0]  ebus_cs,
  input  logic [2:0]  ebus_func,
  input  logic        ebus_demand,
  input  logic        ebus_disable_cs,
  input  logic [2:0]  ebus_pi_lvl,
  input  logic [35:0] ebus_data_in,
  output logic        ebus_ack,
  output logic        ebus_xfer,
  output logic [35:0] ebus_data_out,
  output logic        ebus_drive,
  output logic [6:0]  pi_req,
  input  logic        dev_done_set,
  output logic        dev_busy,
  output logic [35:0] dev_dout,
  output logic        dev_dout_stb
);
  localparam logic [2:0] CNT_INIT = 3'(ACK_DLY - 1);

  tDevState    state_q, state_d;
  tEBUSfunc    func_in, func_q;
  logic [35:0] din_q, buf_q, stat;
  logic [2:0]  cnt_q, pia_q;
  logic        arm_q, ien_q, busy_q, done_q;
  logic        match, commit, rd;

  assign func_in = tEBUSfunc'(ebus_func);

  // transaction match; arm_q blocks a demand left high across a reset
  always_comb begin
    match = 1'b0;
    if (ebus_demand && arm_q) begin
      case (func_in)
        F_CONO, F_CONI, F_DATAO, F_DATAI, F_PI_SERV:
          match = ~ebus_disable_cs && (ebus_cs == DEV_CS);
        F_PI_ADR_IN:
          match = (ebus_pi_lvl == pia_q) && done_q && ien_q;
        default: match = 1'b0;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state; demand dropping in WAIT aborts without side effects
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (match) state_d = S_WAIT;
      S_WAIT: if (!ebus_demand)       state_d = S_IDLE;
              else if (cnt_q == 3'd0) state_d = S_ACK;
      S_ACK:  state_d = S_HOLD;
      S_HOLD: if (!ebus_demand) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // writes land on the edge into ACK so they are visible during ACK
  assign commit = (state_q == S_WAIT) && (state_d == S_ACK);

  // request latch, ACK delay counter and re-arm tracking
  always_ff @(posedge clk) begin
    if (RESET) begin
      arm_q  <= 1'b0;
      func_q <= F_CONO;
      din_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (!ebus_demand) arm_q <= 1'b1;
      if ((state_q == S_IDLE) && match) begin
        func_q <= func_in;
        din_q  <= ebus_data_in;
        cnt_q  <= CNT_INIT;
      end else if ((state_q == S_WAIT) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  // status flags and data buffer; local done pulse has the last word
  always_ff @(posedge clk) begin
    if (RESET) begin
      ien_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pia_q  <= '0;
      buf_q  <= '0;
    end else begin
      if (commit && (func_q == F_CONO)) begin
        if (din_q[CO_CLR_DONE]) done_q <= 1'b0;
        if (din_q[CO_CLR_BUSY])      busy_q <= 1'b0;
        else if (din_q[CO_SET_BUSY]) busy_q <= 1'b1;
        ien_q <= din_q[CO_IEN];
        pia_q <= din_q[CO_PIA_LO +: 3];
      end
      if (commit && (func_q == F_DATAO)) buf_q <= din_q;
      if (dev_done_set) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  // bus outputs; read drive drops combinationally with demand in HOLD
  always_comb begin
    stat = '0;
    stat[ST_IEN]          = ien_q;
    stat[ST_BUSY]         = busy_q;
    stat[ST_DONE]         = done_q;
    stat[ST_PIA_LO +: 3]  = pia_q;
    rd           = is_read(func_q);
    ebus_ack     = (state_q == S_ACK);
    ebus_drive   = rd && ((state_q == S_ACK) || ((state_q == S_HOLD) && ebus_demand));
    ebus_xfer    = ebus_drive;
    dev_dout_stb = (state_q == S_ACK) && (func_q == F_DATAO);
    ebus_data_out = '0;
    if (ebus_drive) begin
      case (func_q)
        F_CONI:  ebus_data_out = stat;
        F_DATAI: ebus_data_out = buf_q;
        default: ebus_data_out = VECTOR;
      endcase
    end
  end

  assign dev_busy = busy_q;
  assign dev_dout = buf_q;

  ebus_pi_req u_pi_req (
    .clk_i    (clk),
    .rst_i    (RESET),
    .done_i   (done_q),
    .ien_i    (ien_q),
    .pia_i    (pia_q),
    .pi_req_o (pi_req)
  );
endmodule

// File: tb/tb_ebus_dev.sv
// Bench for ebus_dev: timestamp-based transaction model checked every
// cycle, plus directed transactions with hand-computed expectations.
module tb_ebus_dev;
  localparam int          AD  = 2;
  localparam logic [6:0]  CS  = 7'o10;
  localparam logic [35:0] VEC = 36'o000000_000123;

  logic        clk, RESET;
  logic [6:0]  ebus_cs;
  logic [2:0]  ebus_func, ebus_pi_lvl;
  logic        ebus_demand, ebus_disable_cs, dev_done_set;
  logic [35:0] ebus_data_in, ebus_data_out, dev_dout;
  logic        ebus_ack, ebus_xfer, ebus_drive, dev_busy, dev_dout_stb;
  logic [6:0]  pi_req;

  ebus_dev #(.DEV_CS(CS), .ACK_DLY(AD), .VECTOR(VEC)) dut (
    .clk(clk), .RESET(RESET), .ebus_cs(ebus_cs), .ebus_func(ebus_func),
    .ebus_demand(ebus_demand), .ebus_disable_cs(ebus_disable_cs),
    .ebus_pi_lvl(ebus_pi_lvl), .ebus_data_in(ebus_data_in),
    .ebus_ack(ebus_ack), .ebus_xfer(ebus_xfer), .ebus_data_out(ebus_data_out),
    .ebus_drive(ebus_drive), .pi_req(pi_req), .dev_done_set(dev_done_set),
    .dev_busy(dev_busy), .dev_dout(dev_dout), .dev_dout_stb(dev_dout_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nerr = 0, stb_cnt = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          rst_seen = 0, m_txn = 0, m_arm = 0;
  bit          m_ien = 0, m_busy = 0, m_done = 0;
  logic [2:0]  m_pia = '0, m_f = '0;
  logic [35:0] m_d = '0, m_buf = '0;
  logic [6:0]  m_pireq = '0;
  int          cyc = 0, m_t0 = 0;

  function automatic logic [35:0] stword();
    logic [35:0] w = '0;
    w[35-27] = m_ien;
    w[35-28] = m_busy;
    w[35-29] = m_done;
    w[2:0]   = m_pia;
    return w;
  endfunction

  function automatic bit mmatch();
    if (!(ebus_demand && m_arm)) return 0;
    if (ebus_func <= 3'd4) return !ebus_disable_cs && (ebus_cs == CS);
    if (ebus_func == 3'd5) return (ebus_pi_lvl == m_pia) && m_done && m_ien;
    return 0;
  endfunction

  always @(posedge clk) begin
    int age;
    cyc++;
    if (RESET) begin
      rst_seen = 1; m_txn = 0; m_arm = 0; m_ien = 0; m_busy = 0; m_done = 0;
      m_pia = '0; m_buf = '0; m_pireq = '0;
    end else begin
      m_pireq = (m_done && m_ien && m_pia != 0) ? 7'(1 << (int'(m_pia) - 1)) : 7'd0;
      age = cyc - m_t0;
      if (!m_txn) begin
        if (mmatch()) begin
          m_txn = 1; m_t0 = cyc; m_f = ebus_func; m_d = ebus_data_in;
        end
      end else if (age <= AD) begin
        if (!ebus_demand) m_txn = 0;
        else if (age == AD) begin
          if (m_f == 3'd0) begin
            if (m_d[35-24]) m_done = 0;
            if (m_d[35-26]) m_busy = 0;
            else if (m_d[35-25]) m_busy = 1;
            m_ien = m_d[35-27];
            m_pia = m_d[2:0];
          end
          if (m_f == 3'd2) m_buf = m_d;
        end
      end else if (age > AD + 1 && !ebus_demand) begin
        m_txn = 0;
      end
      if (!ebus_demand) m_arm = 1;
      if (dev_done_set) begin m_done = 1; m_busy = 0; end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    int age;
    bit e_ack, e_drv, rdf;
    logic [35:0] e_data;
    if (dev_dout_stb) stb_cnt++;
    if (rst_seen) begin
      age   = cyc - m_t0;
      e_ack = m_txn && (age == AD);
      rdf   = (m_f == 3'd1) || (m_f == 3'd3) || (m_f == 3'd5);
      e_drv = m_txn && rdf && ((age == AD) || (age > AD && ebus_demand));
      e_data = !e_drv ? 36'd0 : (m_f == 3'd1) ? stword() : (m_f == 3'd3) ? m_buf : VEC;
      chk("ack", ebus_ack, e_ack);
      chk("xfer", ebus_xfer, e_drv);
      chk("drive", ebus_drive, e_drv);
      chk("data_out", ebus_data_out, e_data);
      chk("pi_req", pi_req, m_pireq);
      chk("dev_dout", dev_dout, m_buf);
      chk("dout_stb", dev_dout_stb, e_ack && (m_f == 3'd2));
      chk("dev_busy", dev_busy, m_busy);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_txn(input logic [2:0] f, input logic [6:0] cs, input logic [35:0] d,
                        input logic [2:0] lvl, input bit dis, input int maxc,
                        output bit got, output int lat, output logic [35:0] rd);
    got = 0; lat = -1; rd = '0;
    ebus_func = f; ebus_cs = cs; ebus_data_in = d; ebus_pi_lvl = lvl;
    ebus_disable_cs = dis; ebus_demand = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ebus_ack && !got) begin got = 1; lat = i; rd = ebus_data_out; end
      @(posedge clk); #1;
      if (got && i >= lat + 2) break;
    end
    ebus_demand = 1'b0; ebus_disable_cs = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got; int lat, acks, s0;
    logic [35:0] rd;
    RESET = 1; ebus_cs = '0; ebus_func = '0; ebus_demand = 0; ebus_disable_cs = 0;
    ebus_pi_lvl = '0; ebus_data_in = '0; dev_done_set = 0;
    tick(); tick();
    RESET = 0;
    @(negedge clk);
    chk("rst_ack", ebus_ack, 0);
    chk("rst_data", ebus_data_out, 0);
    chk("rst_pireq", pi_req, 0);
    chk("rst_dout", dev_dout, 0);
    tick();

    // CONO IEN=1 PIA=5, then read it back
    do_txn(3'd0, CS, 36'o000000_000405, 3'd0, 0, 12, got, lat, rd);
    chk("cono_ack", got, 1);
    chk("cono_lat", lat, 3);
    do_txn(3'd1, CS, '0, 3'd0, 0, 12, got, lat, rd);
    chk("coni_word", rd, 36'o000000_000405);

    // DATAO then DATAI
    s0 = stb_cnt;
    do_txn(3'd2, CS, 36'o123456_701234, 3'd0, 0, 12, got, lat, rd);
    chk("datao_stb_once", stb_cnt - s0, 1);
    chk("datao_dout", dev_dout, 36'o123456_701234);
    do_txn(3'd3, CS, '0, 3'd0, 0, 12, got, lat, rd);
    chk("datai_word", rd, 36'o123456_701234);
    chk("datai_drive_off", ebus_drive, 0);

    // DONE -> PI request on level 5, then vector fetch
    dev_done_set = 1; tick(); dev_done_set = 0; tick();
    @(negedge clk);
    chk("pireq_lvl5", pi_req, 7'b0010000);
    tick();
    do_txn(3'd5, 7'o77, '0, 3'd5, 0, 12, got, lat, rd);
    chk("piadr_ack", got, 1);
    chk("piadr_vec", rd, 36'o000000_000123);
    do_txn(3'd5, 7'o77, '0, 3'd4, 0, 12, got, lat, rd);
    chk("piadr_lvl4_noack", got, 0);

    // wrong CS / disabled CS: nothing happens
    do_txn(3'd0, 7'o11, '0, 3'd0, 0, 20, got, lat, rd);
    chk("wrongcs_noack", got, 0);
    do_txn(3'd0, CS, '0, 3'd0, 1, 20, got, lat, rd);
    chk("discs_noack", got, 0);
    do_txn(3'd1, CS, '0, 3'd0, 0, 12, got, lat, rd);
    chk("status_unchanged", rd, 36'o000000_000505);

    // BUSY set, then set+clear together -> clear wins
    do_txn(3'd0, CS, 36'o000000_002405, 3'd0, 0, 12, got, lat, rd);
    chk("busy_set", dev_busy, 1);
    do_txn(3'd0, CS, 36'o000000_003405, 3'd0, 0, 12, got, lat, rd);
    chk("busy_clr_wins", dev_busy, 0);

    // clear-DONE alone, then colliding with dev_done_set
    do_txn(3'd0, CS, 36'o000000_004405, 3'd0, 0, 12, got, lat, rd);
    do_txn(3'd1, CS, '0, 3'd0, 0, 12, got, lat, rd);
    chk("done_cleared", rd, 36'o000000_000405);
    ebus_func = 3'd0; ebus_cs = CS; ebus_data_in = 36'o000000_004405; ebus_demand = 1;
    tick(); tick();
    dev_done_set = 1; tick(); dev_done_set = 0;
    @(negedge clk);
    chk("collide_ack", ebus_ack, 1);
    tick(); tick();
    ebus_demand = 0; tick(); tick();
    do_txn(3'd1, CS, '0, 3'd0, 0, 12, got, lat, rd);
    chk("collide_done_set", rd, 36'o000000_000505);

    // RESET in WAIT with demand held high
    ebus_func = 3'd1; ebus_cs = CS; ebus_demand = 1;
    tick();
    RESET = 1; tick(); RESET = 0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ebus_ack) acks++;
      tick();
    end
    chk("rst_wait_noack", acks, 0);
    chk("rst_wait_status", dev_busy, 0);
    ebus_demand = 0; tick();
    do_txn(3'd1, CS, '0, 3'd0, 0, 12, got, lat, rd);
    chk("rearm_ack", got, 1);
    chk("rearm_coni", rd, 36'o0);

    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
